// File: rtl/riscv_timer_if.sv
// Bus port bundle for the machine timer: one request per cycle, ack/rdata one cycle later.
interface riscv_timer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/riscv_timer.sv
// RISC-V machine timer (mtime/mtimecmp) on a 16-byte register window.
// Optional prescaler enabled by defining RISCV_TIMER_PRESCALE_EN.
module riscv_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int          PRESCALE  = 4
) (
  input  logic           clk,
  input  logic           rst,
  riscv_timer_if.slave   bus,
  output logic           timer_irq
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] rd_val;
  logic [1:0]  idx;
  logic        sel;
  logic        wr;
  logic        mtime_wr;
  logic        tick;
  logic        unused_bits;

  assign sel      = bus.req && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign idx      = bus.addr[3:2];
  assign wr       = sel && bus.we;
  assign mtime_wr = wr && !idx[1];

  assign unused_bits = &{1'b0, bus.addr[1:0], (PRESCALE == 0)};

`ifdef RISCV_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  // A write to mtime restarts the tick phase so software sees a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pre_cnt <= '0;
    else if (mtime_wr || tick) pre_cnt <= '0;
    else                      pre_cnt <= pre_cnt + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rd_val = '0;
    case (idx)
      2'd0: rd_val = mtime[31:0];
      2'd1: rd_val = mtime[63:32];
      2'd2: rd_val = mtimecmp[31:0];
      2'd3: rd_val = mtimecmp[63:32];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= sel;
      bus.rdata <= (sel && !bus.we) ? rd_val : '0;
    end
  end

  // Half writes load only that half; the tick is suppressed so no carry crosses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (mtime_wr) begin
      if (idx[0]) mtime[63:32] <= bus.wdata;
      else        mtime[31:0]  <= bus.wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
    end else if (wr && idx[1]) begin
      if (idx[0]) mtimecmp[63:32] <= bus.wdata;
      else        mtimecmp[31:0]  <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_irq <= 1'b0;
    else     timer_irq <= (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_riscv_timer.sv
// Directed bench for riscv_timer: per-cycle scoreboard of ack/rdata/timer_irq.
module tb_riscv_timer;

  localparam logic [31:0] BASE = 32'h0000_8000;
`ifdef RISCV_TIMER_PRESCALE_EN
  localparam int TICK = 4;
`else
  localparam int TICK = 1;
`endif

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timer_irq;
  riscv_timer_if bus ();

  riscv_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference timer state: mtime = base + elapsed edges / TICK since last load.
  logic [63:0] base;
  int          ref_edge;
  logic [63:0] cmp;
  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        saw_rise;

  function automatic logic [63:0] mt_now();
    return base + 64'((cyc - ref_edge) / TICK);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    exp_t        got;
    logic [63:0] cur;
    logic        s;
    cur     = mt_now();
    s       = r && (a[31:4] == BASE[31:4]);
    e.ack   = s;
    e.rdata = '0;
    e.irq   = (cur >= cmp);
    if (s && !w) begin
      case (a[3:2])
        2'd0: e.rdata = cur[31:0];
        2'd1: e.rdata = cur[63:32];
        2'd2: e.rdata = cmp[31:0];
        default: e.rdata = cmp[63:32];
      endcase
    end
    bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d;
    q.push_back(e);
    if (s && w) begin
      case (a[3:2])
        2'd0: begin base = {cur[63:32], d}; ref_edge = cyc + 1; end
        2'd1: begin base = {d, cur[31:0]};  ref_edge = cyc + 1; end
        2'd2: cmp[31:0]  = d;
        default: cmp[63:32] = d;
      endcase
    end
    @(negedge clk);
    got = q.pop_front();
    chk("ack",   {31'd0, bus.ack},   {31'd0, got.ack});
    chk("rdata", bus.rdata,          got.rdata);
    chk("irq",   {31'd0, timer_irq}, {31'd0, got.irq});
  endtask

  task automatic rd(input logic [3:0] off);
    drive(1'b1, 1'b0, BASE + {28'd0, off}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    drive(1'b1, 1'b1, BASE + {28'd0, off}, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic reset_model();
    base = '0; ref_edge = 0; cmp = '1;
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_ack",   {31'd0, bus.ack},   32'd0);
    chk("rst_rdata", bus.rdata,          32'd0);
    chk("rst_irq",   {31'd0, timer_irq}, 32'd0);
    rst = 1'b0;

    // Reset values, back-to-back reads
    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);

    // mtimecmp = 20, poll for the interrupt, then clear it via the high half
    wr(4'hC, 32'd0);
    wr(4'h8, 32'd20);
    saw_rise = 1'b0;
    for (int i = 0; i < 22 * TICK + 4; i++) begin
      idle(1);
      if (timer_irq) saw_rise = 1'b1;
    end
    chk("irq_rose", {31'd0, saw_rise}, 32'd1);
    wr(4'hC, 32'd1);
    idle(2);

    // Low-half write: no carry on the write cycle, carry on the next tick
    wr(4'h4, 32'd0);
    wr(4'h0, 32'hFFFF_FFFF);
    idle(TICK);
    rd(4'h0); rd(4'h4);

    // Wrap to 0 with mtimecmp = 5 drops the interrupt
    wr(4'hC, 32'd0);
    wr(4'h8, 32'd5);
    idle(2);
    chk("irq_set", {31'd0, timer_irq}, 32'd1);
    wr(4'h4, 32'hFFFF_FFFF);
    wr(4'h0, 32'hFFFF_FFFF);
    idle(TICK + 2);
    chk("irq_wrap", {31'd0, timer_irq}, 32'd0);
    rd(4'h0); rd(4'h4);

    // Four accesses with req held high
    rd(4'h0); rd(4'h4); wr(4'hC, 32'hA5A5_0001); rd(4'hC);

    // Out-of-window write: no ack, no change
    drive(1'b1, 1'b1, BASE + 32'h10, 32'h1234_5678);
    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);

    // Reset asserted during a selected write cancels ack and the write
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE + 32'hC; bus.wdata = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", {31'd0, bus.ack},   32'd0);
    chk("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
    bus.req = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack2", {31'd0, bus.ack}, 32'd0);
    reset_model();
    rst = 1'b0;
    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
